register_scoreboard: RTL and testbench
======================================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 Parameter: CNT_W, default 2, width of each per-register in-flight write counter; maximum count is 2^CNT_W-1.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: issue_valid  input  1  decode stage presents an instruction this cycle.
REQ-005 Port: issue_has_dest  input  1  the instruction writes a destination register; driven by the destination-detection logic.
REQ-006 Port: issue_rd  input  5  destination register of the issuing instruction.
REQ-007 Port: src_a, src_b  input  5 each  source registers read by the issuing instruction.
REQ-008 Port: src_a_used, src_b_used  input  1 each  the corresponding source is actually read.
REQ-009 Port: wb_valid  input  1  writeback retires one register write this cycle.
REQ-010 Port: wb_rd  input  5  register being written back.
REQ-011 Port: stall  output  1  the issuing instruction must not advance this cycle.
REQ-012 Port: pending  output  32  bit r high when register r has a nonzero counter.
REQ-013 Port: busy  output  1  OR of pending.
REQ-014 Port: wb_error  output  1  sticky flag set by a writeback to a register with no outstanding write.

Function
REQ-015 Each of registers 1..31 SHALL have one CNT_W-bit counter of outstanding writes; register 0 SHALL have no counter, and pending[0] SHALL be constant 0.
REQ-016 stall SHALL be high when issue_valid is high and any of the following holds: src_a_used with pending[src_a]; src_b_used with pending[src_b]; issue_has_dest with issue_rd nonzero and the counter of issue_rd at its maximum.
REQ-017 stall SHALL be combinational from the registered counters and the current-cycle inputs, with zero-cycle latency.
REQ-018 An issue is accepted when issue_valid is high and stall is low; an accepted issue with issue_has_dest high and issue_rd nonzero SHALL increment that counter on the next edge.
REQ-019 When wb_valid is high, wb_rd is nonzero, and the counter of wb_rd is nonzero, that counter SHALL decrement on the next edge.
REQ-020 If an accepted increment and a decrement target the same register in the same cycle, the counter SHALL remain unchanged.
REQ-021 When wb_valid is high, wb_rd is nonzero, and the counter of wb_rd is zero (with no simultaneous increment to wb_rd), the counter SHALL stay at 0 and wb_error SHALL set on the next edge.
REQ-022 wb_error SHALL clear only on reset.
REQ-023 wb_rd equal to 0 SHALL be ignored entirely, including for wb_error.
REQ-024 Counters SHALL never wrap: no increment at the maximum (guaranteed by REQ-016), and no decrement below 0.
REQ-025 pending and busy SHALL reflect the registered counters, with one-cycle latency after the update.

Reset
REQ-026 While reset is low, all counters, pending, busy, and wb_error SHALL be 0 immediately, regardless of clock.
REQ-027 A reset asserted mid-operation SHALL discard all outstanding writes.
REQ-028 While reset is low, stall SHALL be 0.

Configuration
REQ-029 Macro SCOREBOARD_WB_BYPASS_EN, when defined: a source hazard SHALL be ignored in the cycle when the same register has wb_valid and a counter of exactly 1 (same-cycle writeback forwarding).
REQ-030 When SCOREBOARD_WB_BYPASS_EN is undefined, REQ-016 applies unmodified.

Structure
REQ-031 A shared package SHALL hold NUM_REGS=32, REG_ADDR_W=5, and the zero-register index constant.
REQ-032 The per-register counter with increment, decrement, saturation, and error detection SHALL be a sub-module named scoreboard_entry, instantiated 31 times.

Verification
REQ-033 Issue rd=5 (has_dest), then issue src_a=5 next cycle -> stall=1 and pending[5]=1; wb rd=5 -> pending[5]=0 the cycle after, and stall drops.
REQ-034 Issue three writes to rd=7 with CNT_W=2, then a fourth -> the fourth is stalled; after one wb to rd=7 the fourth is accepted and the counter returns to 3.
REQ-035 Same-cycle accepted issue rd=9 and wb rd=9 with counter=1 -> counter stays 1 and pending[9] stays 1.
REQ-036 wb rd=12 with counter 0 -> wb_error=1 and stays 1; wb rd=0 or issue rd=0 -> no counter change and no error.
REQ-037 With counters nonzero, assert reset mid-cycle -> pending=0, busy=0, and wb_error=0 immediately, without a clock edge.
REQ-038 With bypass enabled, counter[3]=1, wb rd=3, and issue src_b=3 in the same cycle -> stall=0; with bypass disabled, the same stimulus -> stall=1.

Source files
------------

// File: rtl/register_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
// The register file geometry lives here so the scoreboard and its
// per-register entries agree on the address width and the hard-wired zero register.
package register_scoreboard_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Register 0 is hard-wired to zero: it has no counter and is never pending.
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard counter: the number of in-flight writes to a single register.
// An increment and a real decrement in the same cycle cancel each other.
// A writeback to an idle register is reported on o_err. The count never wraps.
module scoreboard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,   // active-low
  input  logic             i_inc,   // accepted issue writes this register
  input  logic             i_wb,    // writeback targets this register
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;
  logic             w_dec;

  assign o_cnt  = r_cnt;
  assign o_full = &r_cnt;
  // Saturating guards: the issue stall already prevents an increment at max.
  assign w_inc  = i_inc & ~o_full;
  assign w_dec  = i_wb & (r_cnt != '0);
  // A writeback with nothing outstanding is an error, unless an issue to
  // the same register arrives in the same cycle.
  assign o_err  = i_wb & (r_cnt == '0) & ~i_inc;

  // Counter update: an increment and a decrement together leave the count unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               r_cnt <= '0;
    else if (w_inc && !w_dec) r_cnt <= r_cnt + 1'b1;
    else if (w_dec && !w_inc) r_cnt <= r_cnt - 1'b1;
  end
endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard. It tracks in-flight writes per register and stalls
// issue on RAW hazards and on counter saturation.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a source read
// proceed in the same cycle as the final writeback to that register.
import register_scoreboard_pkg::*;

module register_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,          // active-low, asynchronous
  input  logic                  issue_valid,
  input  logic                  issue_has_dest,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  src_a_used,
  input  logic                  src_b_used,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  busy,
  output logic                  wb_error
);
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS-1:0]            w_full;
  logic [NUM_REGS-1:1]            w_inc;
  logic [NUM_REGS-1:1]            w_wb;
  logic [NUM_REGS-1:1]            w_err;
  logic                           w_byp_a;
  logic                           w_byp_b;
  logic                           w_haz_a;
  logic                           w_haz_b;
  logic                           w_dest_full;
  logic                           w_accept;
  logic                           r_wb_error;

  // The zero register has no entry, so it reads as idle and never full.
  assign w_cnt[ZERO_REG]  = '0;
  assign w_full[ZERO_REG] = 1'b0;
  assign pending[ZERO_REG] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      assign w_inc[gi]   = w_accept & issue_has_dest & (issue_rd == REG_ADDR_W'(gi));
      assign w_wb[gi]    = wb_valid & (wb_rd == REG_ADDR_W'(gi));
      assign pending[gi] = |w_cnt[gi];

      scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
        .clock  (clock),
        .reset  (reset),
        .i_inc  (w_inc[gi]),
        .i_wb   (w_wb[gi]),
        .o_cnt  (w_cnt[gi]),
        .o_full (w_full[gi]),
        .o_err  (w_err[gi])
      );
    end
  endgenerate

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The final outstanding write retires this cycle, so the value is forwarded.
  assign w_byp_a = wb_valid & (wb_rd == src_a) & (w_cnt[src_a] == CNT_W'(1));
  assign w_byp_b = wb_valid & (wb_rd == src_b) & (w_cnt[src_b] == CNT_W'(1));
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_haz_a     = src_a_used & (w_cnt[src_a] != '0) & ~w_byp_a;
  assign w_haz_b     = src_b_used & (w_cnt[src_b] != '0) & ~w_byp_b;
  // A full counter stalls even if a writeback would free a slot this cycle.
  assign w_dest_full = issue_has_dest & (issue_rd != ZERO_REG) & w_full[issue_rd];
  // Gating by reset keeps stall low while the block is held in reset.
  assign stall       = reset & issue_valid & (w_haz_a | w_haz_b | w_dest_full);
  assign w_accept    = issue_valid & ~stall;

  assign busy     = |pending;
  assign wb_error = r_wb_error;

  // Sticky error for a writeback with no outstanding write. Only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_wb_error <= 1'b0;
    else if (|w_err) r_wb_error <= 1'b1;
  end
endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios, then
// randomized traffic against a count-per-register reference model.
// Build with SCOREBOARD_WB_BYPASS_EN defined to cover the forwarding variant.
module tb_register_scoreboard;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 0, issue_has_dest = 0, src_a_used = 0, src_b_used = 0, wb_valid = 0;
  logic [4:0]  issue_rd = 0, src_a = 0, src_b = 0, wb_rd = 0;
  logic        stall, busy, wb_error;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;
  int m_cnt[32];
  bit m_err;
  logic last_stall;

  register_scoreboard #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_has_dest(issue_has_dest), .issue_rd(issue_rd),
    .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .pending(pending), .busy(busy), .wb_error(wb_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit src_hazard(input logic used, input logic [4:0] r);
    if (!used || m_cnt[r] == 0) return 1'b0;
    if (BYP && wb_valid && wb_rd == r && m_cnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    return src_hazard(src_a_used, src_a) || src_hazard(src_b_used, src_b) ||
           (issue_has_dest && issue_rd != 0 && m_cnt[issue_rd] == MAXC);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] != 0);
    return p;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, check stall, advance the model, then check the state.
  task automatic cyc(input logic v, input logic hd, input logic [4:0] rd,
                     input logic au, input logic [4:0] a, input logic bu, input logic [4:0] b,
                     input logic wv, input logic [4:0] wr);
    bit exp_st, inc, dec, err;
    issue_valid = v; issue_has_dest = hd; issue_rd = rd;
    src_a_used = au; src_a = a; src_b_used = bu; src_b = b;
    wb_valid = wv; wb_rd = wr;
    #1;
    exp_st = m_stall();
    last_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, exp_st});
    inc = v && !exp_st && hd && rd != 0;
    dec = wv && wr != 0 && m_cnt[wr] > 0;
    err = wv && wr != 0 && m_cnt[wr] == 0 && !(inc && rd == wr);
    @(posedge clock);
    if (!(inc && dec && rd == wr)) begin
      if (inc) m_cnt[rd]++;
      if (dec) m_cnt[wr]--;
    end
    if (err) m_err = 1'b1;
    #1;
    chk("pending", pending, m_pend());
    chk("busy", {31'd0, busy}, {31'd0, |m_pend()});
    chk("wb_error", {31'd0, wb_error}, {31'd0, m_err});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between clock edges and check that it takes effect immediately.
  task automatic mid_reset();
    @(negedge clock);
    #2;
    issue_valid = 1; src_a_used = 1; src_a = 5'd1; issue_has_dest = 0; wb_valid = 0;
    reset = 1'b0;
    #1;
    chk("rst_pending", pending, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_error", {31'd0, wb_error}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    m_clear();
    issue_valid = 0; src_a_used = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    m_clear();
    #1;
    chk("reset_pending", pending, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wb_error", {31'd0, wb_error}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    #21 reset = 1'b1;

    // Read-after-write hazard on register 5
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("raw_stall", {31'd0, last_stall}, 32'd1);
    chk("raw_pend5", {31'd0, pending[5]}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("raw_pend5_clr", {31'd0, pending[5]}, 32'd0);
    cyc(1, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("raw_stall_drop", {31'd0, last_stall}, 32'd0);

    // Saturation of register 7
    repeat (3) cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat_stall", {31'd0, last_stall}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat_accept", {31'd0, last_stall}, 32'd0);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("sat_back_to_max", {31'd0, last_stall}, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("sat_drained", {31'd0, pending[7]}, 32'd0);

    // Issue and writeback to register 9 in the same cycle
    cyc(1, 1, 9, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0, 0, 1, 9);
    chk("same_cyc_pend9", {31'd0, pending[9]}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
    chk("same_cyc_cnt1", {31'd0, pending[9]}, 32'd0);

    // Register 0 is ignored, and a writeback to an idle register sets the error
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("zero_no_err", {31'd0, wb_error}, 32'd0);
    chk("zero_no_pend", pending, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12);
    chk("err_set", {31'd0, wb_error}, 32'd1);
    idle();
    chk("err_sticky", {31'd0, wb_error}, 32'd1);

    // Same-cycle writeback forwarding on register 3
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 3);
    chk("bypass_stall", {31'd0, last_stall}, BYP ? 32'd0 : 32'd1);

    // Reset in the middle of operation discards outstanding writes
    cyc(1, 1, 20, 0, 0, 0, 0, 0, 0);
    mid_reset();
    idle();

    // Randomized traffic, biased toward a few registers so that hazards occur
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r_rd, r_a, r_b, r_w;
      r_rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      r_a  = 5'($urandom_range(0, 6));
      r_b  = 5'($urandom_range(0, 6));
      r_w  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), r_rd,
          1'($urandom_range(0, 1)), r_a, 1'($urandom_range(0, 1)), r_b,
          1'($urandom_range(0, 2) == 0), r_w);
      if (n % 600 == 599) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
